// File: rtl/counter_seq_pkg.sv
// Shared types and register map for the counter sequencer.
package counter_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      OVR  = 2'd3
   } seq_state_t;

   // Register offsets, selected by wbs_adr_i[3:2]
   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_COUNT   = 2'd1;
   localparam logic [1:0] REG_COMPARE = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   // CTRL bit positions
   localparam int unsigned CTRL_EN        = 0;
   localparam int unsigned CTRL_DIR       = 1;
   localparam int unsigned CTRL_ONESHOT   = 2;
   localparam int unsigned CTRL_IRQ_EN    = 3;
   localparam int unsigned CTRL_PRESC_LSB = 8;

   // STATUS bit positions
   localparam int unsigned STATUS_MATCH   = 0;
   localparam int unsigned STATUS_RUNNING = 1;
   localparam int unsigned STATUS_LA_OVR  = 2;

   // Expand the four byte-lane selects into a 32-bit write mask
   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      logic [31:0] m;
      m = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         m[i*8 +: 8] = {8{sel[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/counter_seq_core.sv
// Count register with prescaled stepping, write-priority mux and match detect.
module counter_seq_core #(
   parameter int unsigned BITS = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   input  logic            up,
   input  logic [7:0]      prescale,
   input  logic            presc_clr,
   input  logic            ovr_en,
   input  logic [BITS-1:0] ovr_val,
   input  logic            load_en,
   input  logic [BITS-1:0] load_val,
   input  logic [BITS-1:0] compare,
   output logic [BITS-1:0] count,
   output logic            match_evt
);

   localparam logic [BITS-1:0] ONE = BITS'(1);

   logic [7:0]      presc;
   logic [7:0]      presc_nxt;
   logic            tick;
   logic [BITS-1:0] step_val;
   logic [BITS-1:0] count_nxt;

   // Next count/prescaler: override beats load beats tick; a lost tick still wraps the prescaler
   always_comb begin
      tick      = run && (presc == prescale);
      step_val  = up ? (count + ONE) : (count - ONE);
      count_nxt = count;
      match_evt = 1'b0;
      if (!run || presc_clr || tick) begin
         presc_nxt = '0;
      end else begin
         presc_nxt = presc + 8'd1;
      end
      if (ovr_en) begin
         count_nxt = ovr_val;
      end else if (load_en) begin
         count_nxt = load_val;
      end else if (tick) begin
         count_nxt = step_val;
         match_evt = (step_val == compare);
      end
   end

   // Count and prescaler state
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         presc <= '0;
      end else begin
         count <= count_nxt;
         presc <= presc_nxt;
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// Wishbone-programmable counter sequencer: WB decode, register file and run-state FSM.
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int unsigned BITS      = 16,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   input  logic            la_ovr_en,
   input  logic [BITS-1:0] la_ovr_val,
   output logic [BITS-1:0] count_o,
   output logic            running_o,
   output logic            irq_o
);

   seq_state_t      state;
   seq_state_t      state_nxt;

   logic            en;
   logic            dir;
   logic            oneshot;
   logic            irq_en;
   logic [7:0]      prescale;
   logic [BITS-1:0] compare;
   logic            match;

   logic            access;
   logic            hit;
   logic            wr;
   logic [1:0]      reg_sel;
   logic            ctrl_wr;
   logic            count_wr;
   logic            compare_wr;
   logic            status_wr;
   logic            en_eff;
   logic [31:0]     wr_mask;
   logic [BITS-1:0] count_ld;
   logic [BITS-1:0] compare_ld;
   logic [31:0]     rd_data;
   logic            match_evt;
   logic            unused_bits;

   assign access     = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
   assign hit        = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign wr         = access && wbs_we_i && hit;
   assign reg_sel    = wbs_adr_i[3:2];
   assign ctrl_wr    = wr && (reg_sel == REG_CTRL);
   assign count_wr   = wr && (reg_sel == REG_COUNT);
   assign compare_wr = wr && (reg_sel == REG_COMPARE);
   assign status_wr  = wr && (reg_sel == REG_STATUS);
   assign wr_mask    = lane_mask(wbs_sel_i);
   assign count_ld   = (count_o & ~wr_mask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wr_mask[BITS-1:0]);
   assign compare_ld = (compare & ~wr_mask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wr_mask[BITS-1:0]);
   assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wr_mask};

   // EN as it will be after this cycle's write, so FSM reacts on the commit edge
   assign en_eff = (ctrl_wr && wbs_sel_i[0]) ? wbs_dat_i[CTRL_EN] : en;

   assign running_o = (state == RUN);
   assign irq_o     = match && irq_en;

   counter_seq_core #(
      .BITS (BITS)
   ) u_core (
      .clk       (wb_clk_i),
      .reset     (wb_rst_i),
      .run       (state == RUN),
      .up        (dir),
      .prescale  (prescale),
      .presc_clr (ctrl_wr && wbs_sel_i[1]),
      .ovr_en    (la_ovr_en),
      .ovr_val   (la_ovr_val),
      .load_en   (count_wr),
      .load_val  (count_ld),
      .compare   (compare),
      .count     (count_o),
      .match_evt (match_evt)
   );

   // Next-state: override wins from any state
   always_comb begin
      state_nxt = state;
      if (la_ovr_en) begin
         state_nxt = OVR;
      end else begin
         case (state)
            IDLE: if (en_eff) state_nxt = RUN;
            RUN: begin
               if (!en_eff)                   state_nxt = IDLE;
               else if (match_evt && oneshot) state_nxt = DONE;
            end
            DONE: begin
               if (en_eff)        state_nxt = RUN;
               else if (count_wr) state_nxt = IDLE;
            end
            OVR:     state_nxt = en_eff ? RUN : IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_nxt;
   end

   // Register file; entering DONE clears EN, a match set beats a same-cycle W1C
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         en       <= 1'b0;
         dir      <= 1'b0;
         oneshot  <= 1'b0;
         irq_en   <= 1'b0;
         prescale <= '0;
         compare  <= '0;
         match    <= 1'b0;
      end else begin
         if (ctrl_wr && wbs_sel_i[0]) begin
            dir     <= wbs_dat_i[CTRL_DIR];
            oneshot <= wbs_dat_i[CTRL_ONESHOT];
            irq_en  <= wbs_dat_i[CTRL_IRQ_EN];
         end
         if (ctrl_wr && wbs_sel_i[1]) begin
            prescale <= wbs_dat_i[CTRL_PRESC_LSB +: 8];
         end
         en <= (state_nxt == DONE && state != DONE) ? 1'b0 : en_eff;
         if (compare_wr) begin
            compare <= compare_ld;
         end
         if (match_evt) begin
            match <= 1'b1;
         end else if (status_wr && wbs_sel_i[0] && wbs_dat_i[STATUS_MATCH]) begin
            match <= 1'b0;
         end
      end
   end

   // Read mux; misses read zero
   always_comb begin
      rd_data = '0;
      if (hit) begin
         case (reg_sel)
            REG_CTRL: begin
               rd_data[CTRL_EN]               = en;
               rd_data[CTRL_DIR]              = dir;
               rd_data[CTRL_ONESHOT]          = oneshot;
               rd_data[CTRL_IRQ_EN]           = irq_en;
               rd_data[CTRL_PRESC_LSB +: 8]   = prescale;
            end
            REG_COUNT:   rd_data[BITS-1:0] = count_o;
            REG_COMPARE: rd_data[BITS-1:0] = compare;
            REG_STATUS: begin
               rd_data[STATUS_MATCH]   = match;
               rd_data[STATUS_RUNNING] = (state == RUN);
               rd_data[STATUS_LA_OVR]  = (state == OVR);
            end
            default: rd_data = '0;
         endcase
      end
   end

   // Single-cycle registered ack, forced low for a cycle after each access
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= access;
         wbs_dat_o <= (access && !wbs_we_i) ? rd_data : '0;
      end
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: WB reads scored against a queue, count traces stepped cycle by cycle.
module tb_counter_sequencer;

   localparam int unsigned BITS = 16;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic            wb_clk_i = 1'b0;
   logic            wb_rst_i;
   logic            wbs_stb_i;
   logic            wbs_cyc_i;
   logic            wbs_we_i;
   logic [3:0]      wbs_sel_i;
   logic [31:0]     wbs_adr_i;
   logic [31:0]     wbs_dat_i;
   logic            wbs_ack_o;
   logic [31:0]     wbs_dat_o;
   logic            la_ovr_en;
   logic [BITS-1:0] la_ovr_val;
   logic [BITS-1:0] count_o;
   logic            running_o;
   logic            irq_o;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   logic [31:0]     rd_exp_q[$];
   string           rd_tag_q[$];
   logic [BITS-1:0] cnt_exp_q[$];

   counter_sequencer #(
      .BITS      (BITS),
      .BASE_ADDR (BASE)
   ) dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .wbs_stb_i  (wbs_stb_i),
      .wbs_cyc_i  (wbs_cyc_i),
      .wbs_we_i   (wbs_we_i),
      .wbs_sel_i  (wbs_sel_i),
      .wbs_adr_i  (wbs_adr_i),
      .wbs_dat_i  (wbs_dat_i),
      .wbs_ack_o  (wbs_ack_o),
      .wbs_dat_o  (wbs_dat_o),
      .la_ovr_en  (la_ovr_en),
      .la_ovr_val (la_ovr_val),
      .count_o    (count_o),
      .running_o  (running_o),
      .irq_o      (irq_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One WB access; returns read data and the number of edges until ack
   task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata, output int unsigned lat);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_adr_i = adr;
      wbs_dat_i = dat;
      wbs_sel_i = sel;
      lat = 0;
      do begin
         @(posedge wb_clk_i);
         #1;
         lat++;
      end while (!wbs_ack_o && lat < 8);
      if (!wbs_ack_o) check("ack_timeout", 32'(wbs_ack_o), 32'd1);
      rdata     = wbs_dat_o;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] rd;
      int unsigned lat;
      wb_cycle(1'b1, adr, dat, sel, rd, lat);
   endtask

   task automatic wb_read(input string tag, input logic [31:0] adr, input logic [31:0] exp,
                          output int unsigned lat);
      logic [31:0] rd;
      rd_exp_q.push_back(exp);
      rd_tag_q.push_back(tag);
      wb_cycle(1'b0, adr, 32'd0, 4'hF, rd, lat);
      check(rd_tag_q.pop_front(), rd, rd_exp_q.pop_front());
   endtask

   // Compare count_o against queued expectations, one per clock
   task automatic expect_counts(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge wb_clk_i);
         @(negedge wb_clk_i);
         if (cnt_exp_q.size() == 0) check("count_q_empty", 32'(cnt_exp_q.size()), 32'd1);
         else                       check("count", 32'(count_o), 32'(cnt_exp_q.pop_front()));
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned lat;

      wb_rst_i   = 1'b1;
      wbs_stb_i  = 1'b0;
      wbs_cyc_i  = 1'b0;
      wbs_we_i   = 1'b0;
      wbs_sel_i  = 4'h0;
      wbs_adr_i  = '0;
      wbs_dat_i  = '0;
      la_ovr_en  = 1'b0;
      la_ovr_val = '0;
      repeat (3) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);

      // Reset state
      check("rst_count", 32'(count_o), 32'd0);
      check("rst_running", 32'(running_o), 32'd0);
      check("rst_irq", 32'(irq_o), 32'd0);
      wb_read("rst_ctrl", BASE + 32'h0, 32'd0, lat);
      check("ack_lat", 32'(lat), 32'd1);
      @(posedge wb_clk_i);
      #1;
      check("ack_drop", 32'(wbs_ack_o), 32'd0);
      wb_read("rst_cnt_rd", BASE + 32'h4, 32'd0, lat);
      wb_read("rst_cmp_rd", BASE + 32'h8, 32'd0, lat);
      wb_read("rst_status", BASE + 32'hC, 32'd0, lat);

      // Count up with PRESCALE 0, match at 5 with IRQ
      wb_write(BASE + 32'h8, 32'd5, 4'hF);
      wb_write(BASE + 32'h0, 32'h0000_000B, 4'hF);
      check("up_start", 32'(count_o), 32'd0);
      for (int unsigned k = 1; k <= 4; k++) cnt_exp_q.push_back(BITS'(k));
      expect_counts(4);
      check("irq_pre", 32'(irq_o), 32'd0);
      cnt_exp_q.push_back(BITS'(5));
      expect_counts(1);
      check("irq_match", 32'(irq_o), 32'd1);
      cnt_exp_q.push_back(BITS'(6));
      expect_counts(1);
      check("irq_hold", 32'(irq_o), 32'd1);
      wb_write(BASE + 32'h0, 32'd0, 4'hF);
      wb_write(BASE + 32'hC, 32'd1, 4'hF);
      wb_read("stat_clr", BASE + 32'hC, 32'd0, lat);
      check("irq_clr", 32'(irq_o), 32'd0);

      // Wrap up with PRESCALE 3, then down through zero
      wb_write(BASE + 32'h4, 32'h0000_FFFF, 4'hF);
      wb_write(BASE + 32'h0, 32'h0000_0303, 4'hF);
      check("wrap_start", 32'(count_o), 32'h0000_FFFF);
      repeat (3) cnt_exp_q.push_back(16'hFFFF);
      cnt_exp_q.push_back(16'h0000);
      expect_counts(4);
      wb_write(BASE + 32'h0, 32'h0000_0301, 4'hF);
      check("down_start", 32'(count_o), 32'd0);
      repeat (3) cnt_exp_q.push_back(16'h0000);
      cnt_exp_q.push_back(16'hFFFF);
      expect_counts(4);
      wb_write(BASE + 32'h0, 32'd0, 4'hF);

      // One-shot stop at 3, EN self-clears, resume with EN=1
      wb_write(BASE + 32'h4, 32'd0, 4'hF);
      wb_write(BASE + 32'h8, 32'd3, 4'hF);
      wb_write(BASE + 32'h0, 32'h0000_000F, 4'hF);
      cnt_exp_q.push_back(16'd1);
      cnt_exp_q.push_back(16'd2);
      cnt_exp_q.push_back(16'd3);
      cnt_exp_q.push_back(16'd3);
      expect_counts(4);
      check("done_running", 32'(running_o), 32'd0);
      check("done_irq", 32'(irq_o), 32'd1);
      wb_read("done_ctrl", BASE + 32'h0, 32'h0000_000E, lat);
      wb_read("done_status", BASE + 32'hC, 32'h0000_0001, lat);
      wb_write(BASE + 32'h0, 32'h0000_000F, 4'hF);
      check("resume_hold", 32'(count_o), 32'd3);
      check("resume_running", 32'(running_o), 32'd1);
      cnt_exp_q.push_back(16'd4);
      expect_counts(1);
      wb_write(BASE + 32'h0, 32'd0, 4'hF);
      wb_write(BASE + 32'hC, 32'd1, 4'hF);

      // LA override beats a concurrent COUNT write, then stepping resumes
      wb_write(BASE + 32'h4, 32'h0000_0100, 4'hF);
      wb_write(BASE + 32'h0, 32'h0000_0003, 4'hF);
      la_ovr_val = 16'h1234;
      la_ovr_en  = 1'b1;
      wb_write(BASE + 32'h4, 32'h0000_0010, 4'hF);
      check("ovr_count", 32'(count_o), 32'h0000_1234);
      check("ovr_running", 32'(running_o), 32'd0);
      wb_read("ovr_status", BASE + 32'hC, 32'h0000_0004, lat);
      la_ovr_en = 1'b0;
      cnt_exp_q.push_back(16'h1234);
      cnt_exp_q.push_back(16'h1235);
      cnt_exp_q.push_back(16'h1236);
      expect_counts(3);
      check("rel_running", 32'(running_o), 32'd1);

      // Match set on the same edge as a W1C: set wins
      wb_write(BASE + 32'h0, 32'd0, 4'hF);
      wb_write(BASE + 32'h4, 32'd0, 4'hF);
      wb_write(BASE + 32'h8, 32'd4, 4'hF);
      wb_write(BASE + 32'hC, 32'd1, 4'hF);
      wb_write(BASE + 32'h0, 32'h0000_000B, 4'hF);
      repeat (3) @(posedge wb_clk_i);
      #1;
      wb_write(BASE + 32'hC, 32'd1, 4'hF);
      check("race_count", 32'(count_o), 32'd4);
      check("race_irq", 32'(irq_o), 32'd1);
      wb_read("race_status", BASE + 32'hC, 32'h0000_0003, lat);
      wb_write(BASE + 32'hC, 32'd1, 4'hF);
      check("w1c_irq", 32'(irq_o), 32'd0);
      wb_read("w1c_status", BASE + 32'hC, 32'h0000_0002, lat);

      // Address misses and byte-lane COUNT merge
      wb_write(BASE + 32'h0, 32'd0, 4'hF);
      wb_read("miss_rd", BASE + 32'h10, 32'd0, lat);
      wb_write(BASE + 32'h18, 32'h0000_0077, 4'hF);
      wb_write(32'h4000_0008, 32'h0000_0099, 4'hF);
      wb_read("miss_wr", BASE + 32'h8, 32'd4, lat);
      wb_write(BASE + 32'h4, 32'h0000_1234, 4'hF);
      wb_write(BASE + 32'h4, 32'h0000_00AB, 4'b0001);
      wb_read("byte_merge", BASE + 32'h4, 32'h0000_12AB, lat);
      wb_write(BASE + 32'h4, 32'hFFFF_5678, 4'hF);
      wb_read("upper_zero", BASE + 32'h4, 32'h0000_5678, lat);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
